fnd_if: RTL and testbench

Output-side interface of the doorlock design: where the debounce interface conditions key inputs before the lock logic, this block conditions the lock's outputs before the board pins. It keeps a 4-digit buffer of entered keys and drives a time-multiplexed 4-digit seven-segment display (FND). It also drives the status LED as off, steady-on, or a finite error blink.

---
 rtl/doorlock_pkg.sv | 23 ++
 rtl/fnd_if_if.sv | 22 ++
 rtl/seg7_dec.sv | 18 +
 rtl/fnd_if.sv | 135 +++++++++++++
 tb/tb_fnd_if.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - shared doorlock glyphs, LED states and default timing
package doorlock_pkg;

   localparam logic [15:0] T_SCAN_DEF  = 16'd50_000;
   localparam logic [23:0] T_BLINK_DEF = 24'd12_500_000;
   localparam logic [1:0]  N_BLINK_DEF = 2'd3;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [0:15][6:0] SEG_HEX = {
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {L_OFF, L_ON, L_BLINK} led_state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] value;
   } digit_t;

endpackage

// File: rtl/fnd_if_if.sv
// rtl/fnd_if_if.sv - key/status inputs and FND/LED pin outputs of fnd_if
interface fnd_if_if;
   logic       key_v_i;
   logic [3:0] key_i;
   logic       clr_i;
   logic       mask_i;
   logic       open_i;
   logic       err_i;
   logic [6:0] seg_o;
   logic [3:0] dig_o;
   logic       led_o;

   modport master (
      output key_v_i, key_i, clr_i, mask_i, open_i, err_i,
      input  seg_o, dig_o, led_o
   );

   modport slave (
      input  key_v_i, key_i, clr_i, mask_i, open_i, err_i,
      output seg_o, dig_o, led_o
   );
endinterface

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - {valid, mask, value} to active-low seven-segment pattern
module seg7_dec
   import doorlock_pkg::*;
(
   input  logic       valid_i,
   input  logic       mask_i,
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (valid_i) begin
         seg_o = mask_i ? SEG_DASH : SEG_HEX[value_i];
      end
   end

endmodule

// File: rtl/fnd_if.sv
// rtl/fnd_if.sv - 4-digit key buffer, multiplexed FND scan and status LED blink
module fnd_if
   import doorlock_pkg::*;
#(
   parameter logic [15:0] T_SCAN  = T_SCAN_DEF,
   parameter logic [23:0] T_BLINK = T_BLINK_DEF,
   parameter logic [1:0]  N_BLINK = N_BLINK_DEF
)(
   input  logic     clk,
   input  logic     n_rst,
   fnd_if_if.slave  bus
);

   localparam int NB  = int'(N_BLINK);
   localparam int SCW = $clog2(T_SCAN);
   localparam int BCW = $clog2(T_BLINK);
   localparam int TCW = $clog2(2 * NB + 1);

   localparam logic [SCW-1:0] SCAN_MAX  = SCW'(T_SCAN - 16'd1);
   localparam logic [BCW-1:0] BLINK_MAX = BCW'(T_BLINK - 24'd1);
   localparam logic [TCW-1:0] TOG_MAX   = TCW'(2 * NB - 1);

   digit_t [3:0]   buf_q, buf_d;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]     idx_q, idx_d;
   logic [6:0]     seg_q, seg_d;
   logic [3:0]     dig_q, dig_d;
   led_state_e     led_state_q, led_state_d;
   logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
   logic [TCW-1:0] tog_cnt_q, tog_cnt_d;
   logic           led_q, led_d;
   digit_t         sel;

   // Clear first, then shift, so a same-cycle key lands in a blank buffer.
   always_comb begin
      buf_d = buf_q;
      if (bus.clr_i) begin
         buf_d = '0;
      end
      if (bus.key_v_i) begin
         buf_d = {buf_d[2:0], digit_t'{valid: 1'b1, value: bus.key_i}};
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_MAX) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end
      dig_d = ~(4'b0001 << idx_d);
   end

   // Decoding from the next idx keeps segments aligned with the enable.
   assign sel = buf_q[idx_d];

   seg7_dec u_dec (
      .valid_i (sel.valid),
      .mask_i  (bus.mask_i),
      .value_i (sel.value),
      .seg_o   (seg_d)
   );

   always_comb begin
      led_state_d = led_state_q;
      blink_cnt_d = blink_cnt_q;
      tog_cnt_d   = tog_cnt_q;
      led_d       = led_q;
      if (bus.open_i) begin
         led_state_d = L_ON;
         led_d       = 1'b1;
      end else if (bus.err_i) begin
         led_state_d = L_BLINK;
         blink_cnt_d = '0;
         tog_cnt_d   = '0;
         led_d       = 1'b1;
      end else begin
         case (led_state_q)
            L_ON: begin
               led_state_d = L_OFF;
               led_d       = 1'b0;
            end
            L_BLINK: begin
               if (blink_cnt_q == BLINK_MAX) begin
                  blink_cnt_d = '0;
                  if (tog_cnt_q == TOG_MAX) begin
                     led_state_d = L_OFF;
                     tog_cnt_d   = '0;
                     led_d       = 1'b0;
                  end else begin
                     tog_cnt_d = tog_cnt_q + 1'b1;
                     led_d     = ~led_q;
                  end
               end else begin
                  blink_cnt_d = blink_cnt_q + 1'b1;
               end
            end
            default: begin
               led_state_d = L_OFF;
               led_d       = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         buf_q       <= '0;
         scan_cnt_q  <= '0;
         idx_q       <= 2'd0;
         seg_q       <= SEG_BLANK;
         dig_q       <= 4'b1110;
         led_state_q <= L_OFF;
         blink_cnt_q <= '0;
         tog_cnt_q   <= '0;
         led_q       <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         led_state_q <= led_state_d;
         blink_cnt_q <= blink_cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         led_q       <= led_d;
      end
   end

   assign bus.seg_o = seg_q;
   assign bus.dig_o = dig_q;
   assign bus.led_o = led_q;

endmodule

// File: tb/tb_fnd_if.sv
// tb/tb_fnd_if.sv - scoreboard bench for fnd_if: scan, buffer, mask, LED blink
module tb_fnd_if;

   typedef struct {
      logic [3:0] dig;
      logic [6:0] seg;
   } seg_exp_t;

   logic clk = 1'b0;
   logic n_rst;
   int   n_chk = 0;
   int   n_fail = 0;

   seg_exp_t   seg_q[$];
   logic [3:0] dig_q[$];
   logic       led_q[$];

   seg_exp_t   s_exp;
   logic [3:0] d_exp;
   logic       l_exp;

   fnd_if_if bus();

   fnd_if #(
      .T_SCAN  (16'd4),
      .T_BLINK (24'd8),
      .N_BLINK (2'd3)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Monitor: per-cycle LED/dig expectations, segment expectations on digit match.
   always @(negedge clk) begin
      if (led_q.size() > 0) begin
         l_exp = led_q.pop_front();
         n_chk++;
         if (bus.led_o !== l_exp) begin
            n_fail++;
            $display("FAIL led_o at %0t: got %b expected %b", $time, bus.led_o, l_exp);
         end
      end
      if (dig_q.size() > 0) begin
         d_exp = dig_q.pop_front();
         n_chk++;
         if (bus.dig_o !== d_exp) begin
            n_fail++;
            $display("FAIL dig_o at %0t: got %b expected %b", $time, bus.dig_o, d_exp);
         end
      end
      if (seg_q.size() > 0 && bus.dig_o == seg_q[0].dig) begin
         s_exp = seg_q.pop_front();
         n_chk++;
         if (bus.seg_o !== s_exp.seg) begin
            n_fail++;
            $display("FAIL seg_o dig=%b at %0t: got %h expected %h",
                     s_exp.dig, $time, bus.seg_o, s_exp.seg);
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      seg_q.push_back('{dig: 4'b1110, seg: s0});
      seg_q.push_back('{dig: 4'b1101, seg: s1});
      seg_q.push_back('{dig: 4'b1011, seg: s2});
      seg_q.push_back('{dig: 4'b0111, seg: s3});
   endtask

   task automatic wait_seg();
      int n = 0;
      while (seg_q.size() > 0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (seg_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL seg_timeout: %0d expectations left, expected 0", seg_q.size());
         seg_q.delete();
      end
   endtask

   function automatic logic [3:0] scan_dig(input int k);
      logic [3:0] d;
      d = ~(4'b0001 << (((k + 1) / 4) % 4));
      return d;
   endfunction

   // Blink pattern for T_BLINK=8, N_BLINK=3: 1x8, 0x8 three times, then 0.
   function automatic logic pat(input int i);
      return (i < 48) && (((i / 8) % 2) == 0);
   endfunction

   initial begin
      n_rst       = 1'b0;
      bus.key_v_i = 1'b0;
      bus.key_i   = 4'd0;
      bus.clr_i   = 1'b0;
      bus.mask_i  = 1'b0;
      bus.open_i  = 1'b0;
      bus.err_i   = 1'b0;

      nxt(); nxt(); nxt();
      dig_q.push_back(4'b1110);
      led_q.push_back(1'b0);
      seg_q.push_back('{dig: 4'b1110, seg: 7'h7F});
      nxt();
      n_rst = 1'b1;
      for (int k = 0; k < 19; k++) begin
         if (k > 0) nxt();
         dig_q.push_back(scan_dig(k));
         led_q.push_back(1'b0);
      end
      wait_seg();

      for (int k = 1; k <= 5; k++) begin
         nxt();
         bus.key_v_i = 1'b1;
         bus.key_i   = 4'(k);
         nxt();
         bus.key_v_i = 1'b0;
      end
      push_frame(7'h12, 7'h19, 7'h30, 7'h24);
      wait_seg();

      nxt();
      bus.clr_i   = 1'b1;
      bus.key_v_i = 1'b1;
      bus.key_i   = 4'd7;
      nxt();
      bus.clr_i   = 1'b0;
      bus.key_v_i = 1'b0;
      push_frame(7'h78, 7'h7F, 7'h7F, 7'h7F);
      wait_seg();

      nxt();
      bus.mask_i = 1'b1;
      nxt();
      push_frame(7'h3F, 7'h7F, 7'h7F, 7'h7F);
      wait_seg();
      bus.mask_i = 1'b0;

      nxt();
      bus.err_i = 1'b1;
      led_q.push_back(1'b1);
      nxt();
      bus.err_i = 1'b0;
      led_q.push_back(pat(1));
      for (int i = 2; i < 20; i++) begin
         nxt();
         led_q.push_back(pat(i));
      end
      nxt();
      bus.err_i = 1'b1;
      led_q.push_back(1'b1);
      nxt();
      bus.err_i = 1'b0;
      led_q.push_back(pat(1));
      for (int i = 2; i < 52; i++) begin
         nxt();
         led_q.push_back(pat(i));
      end

      nxt();
      bus.err_i = 1'b1;
      led_q.push_back(1'b1);
      nxt();
      bus.err_i = 1'b0;
      led_q.push_back(pat(1));
      for (int i = 2; i < 10; i++) begin
         nxt();
         led_q.push_back(pat(i));
      end
      nxt();
      bus.open_i = 1'b1;
      led_q.push_back(1'b1);
      for (int i = 0; i < 3; i++) begin
         nxt();
         led_q.push_back(1'b1);
      end
      nxt();
      bus.err_i = 1'b1;
      led_q.push_back(1'b1);
      nxt();
      bus.err_i = 1'b0;
      led_q.push_back(1'b1);
      nxt();
      led_q.push_back(1'b1);
      nxt();
      bus.open_i = 1'b0;
      led_q.push_back(1'b0);
      for (int i = 0; i < 10; i++) begin
         nxt();
         led_q.push_back(1'b0);
      end

      nxt();
      bus.err_i = 1'b1;
      led_q.push_back(1'b1);
      nxt();
      bus.err_i = 1'b0;
      led_q.push_back(pat(1));
      for (int i = 2; i < 6; i++) begin
         nxt();
         led_q.push_back(pat(i));
      end
      nxt();
      n_rst       = 1'b0;
      bus.key_v_i = 1'b1;
      bus.key_i   = 4'd9;
      led_q.push_back(1'b0);
      dig_q.push_back(4'b1110);
      seg_q.push_back('{dig: 4'b1110, seg: 7'h7F});
      nxt();
      n_rst       = 1'b1;
      bus.key_v_i = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) nxt();
         dig_q.push_back(scan_dig(k));
         led_q.push_back(1'b0);
      end
      nxt();
      push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
      wait_seg();

      nxt();
      nxt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
